tournament_bp: RTL
==================

# tournament_bp

Parametrised tournament branch predictor for the fetch stage of the 2-way core: a per-PC local predictor and a gshare predictor, arbitrated by a per-PC chooser, with a BTB and a speculative global history register (GHR). It adds a real chooser, tagged BTB entries, configurable table sizes and warm-up length, and GHR repair on a mispredict. Prediction is combinational in the fetch cycle. Table training and GHR repair happen on the clock edge, driven by resolved branches from EX.

## Interface
- `IDX_W`, 5: index width of the local, gshare, chooser and BTB tables; each table has 2^IDX_W entries.
- `GHR_W`, 5: GHR width; must be ≤ IDX_W.
- `WARMUP`, 10: number of resolved branches before the chooser is used; range 1..255.
- `TAG_W`, 8: BTB tag width.

Ports:
- `clk` in 1: clock.
- `Reset_n` in 1: asynchronous, active-low reset.
- `PC` in 32: fetch PC.
- `nextPC` in 32: sequential fall-through address.
- `Branch` in 1: fetch instruction is a conditional branch.
- `prediction` out 1: predicted taken.
- `predicted_address` out 32: next fetch address.
- `pred_src` out 1: component used; 1 = gshare, 0 = local.
- `GHR` out GHR_W: GHR snapshot before this branch's shift; travels down the pipe.
- `Branch_EX` in 1: resolved branch valid in EX.
- `PC_EX` in 32: PC of the resolved branch.
- `branchTaken` in 1: actual outcome.
- `branch_target_EX` in 32: actual target.
- `GHR_in` in GHR_W: snapshot that travelled down the pipe with the branch.
- `mispredict_EX` in 1: direction or target was wrong; triggers GHR repair.

## Operation
- Local index `li = PC[IDX_W+1:2]`.
- Gshare index `gi = li ^ {0, GHR}`, with GHR zero-extended to IDX_W.
- BTB tag = `PC[IDX_W+TAG_W+1:IDX_W+2]`.
- All counters are 2-bit saturating; a counter predicts taken when it is ≥ 2.
- Direction select:
  - while `warm_cnt < WARMUP`: use local, `pred_src=0`.
  - otherwise: `chooser[li] >= 2` selects gshare, else local.
- BTB hit = valid & tag match.
- `prediction = Branch & dir & hit`.
- `predicted_address` = BTB target if `prediction`, else `nextPC`.
- When `Branch=0`: `prediction=0`, `predicted_address=nextPC`, and `pred_src` is don't-care (drive 0).
- Speculative GHR: on a clock edge with `Branch=1`, `GHR <= {GHR[GHR_W-2:0], prediction}`.
- Repair: on a clock edge with `Branch_EX & mispredict_EX`, `GHR <= {GHR_in[GHR_W-2:0], branchTaken}`. Repair overrides a same-cycle fetch shift.
- Training on a clock edge with `Branch_EX`. Indices are recomputed from `PC_EX` and `GHR_in`.
  - Local counter: trained toward `branchTaken`.
  - Gshare counter: trained toward `branchTaken`.
  - Chooser: only when local and gshare disagreed, step toward the correct one (+1 toward gshare, −1 toward local).
  - BTB: if `branchTaken`, write valid=1, tag and `branch_target_EX`. A not-taken branch does not invalidate its BTB entry.
  - `warm_cnt` increments and saturates at `WARMUP`.
- Same-index read and write in one cycle: the fetch read returns the pre-update value (no bypass).

## Timing
- Prediction path is purely combinational from `PC`, `Branch`, `nextPC` and the current table state (zero latency).
- Table, GHR and `warm_cnt` updates take effect at the clock edge after `Branch_EX` is sampled. They are visible to fetch in the next cycle.
- Reset (async, any cycle, including mid-training):
  - local and gshare counters = 01 (weakly not-taken).
  - chooser = 01 (weakly local).
  - BTB valid = 0.
  - GHR = 0, `warm_cnt` = 0.
  - Resulting outputs: `prediction=0`, `predicted_address=nextPC`, `pred_src=0`, `GHR=0`.
- Counter saturation:
  - 11 + taken stays 11.
  - 00 + not-taken stays 00.
  - chooser 11/00 likewise.
- `warm_cnt` is 8 bits. Once it reaches `WARMUP` it stays there until reset.

## Configuration
- `TOURNAMENT_BP_TAG_EN`:
  - Defined: the BTB stores a TAG_W tag, and a hit requires valid and tag match.
  - Undefined: no tag storage, and a hit = valid only. Aliasing PCs then share a target.

## Test plan
- Reset, then `PC=0x40`, `Branch=1` -> `prediction=0`, `predicted_address=nextPC=0x44`, `GHR=0`.
- Train `PC=0x40` taken to target `0x100` twice -> next fetch of 0x40 gives `prediction=1`, `predicted_address=0x100`, `pred_src=0` (still warming).
- 10 resolved branches, with gshare correct and local wrong on an alternating pattern -> chooser at `li` reaches ≥ 2 and `pred_src=1`.
- Fetch shifts GHR to `0b00011`; assert `mispredict_EX` with `GHR_in=0b00001`, `branchTaken=0` and `Branch=1` in the same cycle -> GHR = `0b00010` (repair wins).
- Drive `Reset_n` low mid-training -> all outputs return to reset values at once, and `warm_cnt` restarts.
- With `TOURNAMENT_BP_TAG_EN` defined, train 0x40; fetch alias 0x40 + (4 << IDX_W) -> no hit, `predicted_address=nextPC`. With it undefined -> hit, target 0x100.

Source files
------------

// File: rtl/tournament_bp.sv
// Tournament branch predictor: local + gshare arbitrated by a per-PC chooser, with BTB and
// speculative GHR. Define TOURNAMENT_BP_TAG_EN to store and compare BTB tags.
module tournament_bp #(
  parameter int unsigned IDX_W  = 5,
  parameter int unsigned GHR_W  = 5,
  parameter int unsigned WARMUP = 10,
  parameter int unsigned TAG_W  = 8
) (
  input  logic              clk,
  input  logic              Reset_n,
  input  logic [31:0]       PC,
  input  logic [31:0]       nextPC,
  input  logic              Branch,
  output logic              prediction,
  output logic [31:0]       predicted_address,
  output logic              pred_src,
  output logic [GHR_W-1:0]  GHR,
  input  logic              Branch_EX,
  input  logic [31:0]       PC_EX,
  input  logic              branchTaken,
  input  logic [31:0]       branch_target_EX,
  input  logic [GHR_W-1:0]  GHR_in,
  input  logic              mispredict_EX
);

  localparam int unsigned Entries   = 1 << IDX_W;
  localparam logic [7:0]  WarmupCnt = 8'(WARMUP);

  logic [1:0]  local_q   [Entries];
  logic [1:0]  gshare_q  [Entries];
  logic [1:0]  chooser_q [Entries];
  logic        btb_valid_q  [Entries];
  logic [31:0] btb_target_q [Entries];
`ifdef TOURNAMENT_BP_TAG_EN
  logic [TAG_W-1:0] btb_tag_q [Entries];
  logic [TAG_W-1:0] fe_tag, ex_tag;
  assign fe_tag = PC[IDX_W+TAG_W+1:IDX_W+2];
  assign ex_tag = PC_EX[IDX_W+TAG_W+1:IDX_W+2];
`endif

  logic [GHR_W-1:0] ghr_q, ghr_d;
  logic [7:0]       warm_q;

  logic [IDX_W-1:0] fe_li, fe_gi, ex_li, ex_gi;
  logic             use_gshare, dir, hit;
  logic             ex_local_pred, ex_gshare_pred;

  logic unused_bits;
  assign unused_bits = ^{PC, PC_EX, GHR_in};

  function automatic logic [1:0] sat_step(input logic [1:0] c, input logic up);
    if (up) return (c == 2'b11) ? c : c + 2'd1;
    else    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  assign fe_li = PC[IDX_W+1:2];
  assign fe_gi = fe_li ^ IDX_W'(ghr_q);
  assign ex_li = PC_EX[IDX_W+1:2];
  assign ex_gi = ex_li ^ IDX_W'(GHR_in);

  always_comb begin
    use_gshare = (warm_q >= WarmupCnt) && chooser_q[fe_li][1];
    dir        = use_gshare ? gshare_q[fe_gi][1] : local_q[fe_li][1];
`ifdef TOURNAMENT_BP_TAG_EN
    hit        = btb_valid_q[fe_li] && (btb_tag_q[fe_li] == fe_tag);
`else
    hit        = btb_valid_q[fe_li];
`endif
    prediction        = Branch & dir & hit;
    predicted_address = prediction ? btb_target_q[fe_li] : nextPC;
    pred_src          = Branch & use_gshare;
  end

  assign GHR = ghr_q;

  assign ex_local_pred  = local_q[ex_li][1];
  assign ex_gshare_pred = gshare_q[ex_gi][1];

  // Repair from EX takes priority over the speculative fetch shift.
  always_comb begin
    ghr_d = ghr_q;
    if (Branch_EX && mispredict_EX) begin
      ghr_d = {GHR_in[GHR_W-2:0], branchTaken};
    end else if (Branch) begin
      ghr_d = {ghr_q[GHR_W-2:0], prediction};
    end
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < Entries; i++) begin
        local_q[i]      <= 2'b01;
        gshare_q[i]     <= 2'b01;
        chooser_q[i]    <= 2'b01;
        btb_valid_q[i]  <= 1'b0;
        btb_target_q[i] <= '0;
`ifdef TOURNAMENT_BP_TAG_EN
        btb_tag_q[i]    <= '0;
`endif
      end
      ghr_q  <= '0;
      warm_q <= '0;
    end else begin
      ghr_q <= ghr_d;
      if (Branch_EX) begin
        local_q[ex_li]  <= sat_step(local_q[ex_li], branchTaken);
        gshare_q[ex_gi] <= sat_step(gshare_q[ex_gi], branchTaken);
        // Chooser only learns when the components disagreed; up means gshare was right.
        if (ex_local_pred != ex_gshare_pred) begin
          chooser_q[ex_li] <= sat_step(chooser_q[ex_li], ex_gshare_pred == branchTaken);
        end
        if (branchTaken) begin
          btb_valid_q[ex_li]  <= 1'b1;
          btb_target_q[ex_li] <= branch_target_EX;
`ifdef TOURNAMENT_BP_TAG_EN
          btb_tag_q[ex_li]    <= ex_tag;
`endif
        end
        if (warm_q < WarmupCnt) warm_q <= warm_q + 8'd1;
      end
    end
  end

endmodule
